// File: rtl/seq_prefix_addsub_pkg.sv
// Shared types and elaboration helpers for the sliced prefix adder/subtractor.
package seq_prefix_addsub_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the slice index: ceil(log2(nchunk)), never less than 1.
  function automatic int idx_width(input int nchunk);
    int r;
    r = 1;
    while ((1 << r) < nchunk) r++;
    return r;
  endfunction

  // True when the operand width splits into whole slices.
  function automatic bit width_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

  // Black-cell merge of a high group (gh, ph) over a lower group (gl, pl).
  function automatic logic [1:0] gp_merge(input logic gh, input logic ph,
                                          input logic gl, input logic pl);
    return {gh | (ph & gl), ph & pl};
  endfunction

endpackage

// File: rtl/seq_prefix_addsub_gp_prefix.sv
// Combinational inclusive prefix G/P network over one slice.
// grp_g[i]/grp_p[i] are the group generate/propagate of bits 1..i.
// Built as a recursive divide-and-conquer (Sklansky-style) tree: the lower
// half's top group is broadcast across every bit of the upper half.
module gp_prefix_chunk
  import seq_prefix_addsub_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK:1] p,
  input  logic [CHUNK:1] g,
  output logic [CHUNK:1] grp_p,
  output logic [CHUNK:1] grp_g
);

  generate
    if (CHUNK == 1) begin : g_leaf
      assign grp_p = p;
      assign grp_g = g;
    end else begin : g_split
      localparam int LO = CHUNK / 2;
      localparam int HI = CHUNK - LO;

      logic [LO:1] lo_p;
      logic [LO:1] lo_g;
      logic [HI:1] hi_p;
      logic [HI:1] hi_g;

      gp_prefix_chunk #(.CHUNK(LO)) u_lo (
        .p     (p[LO:1]),
        .g     (g[LO:1]),
        .grp_p (lo_p),
        .grp_g (lo_g)
      );

      gp_prefix_chunk #(.CHUNK(HI)) u_hi (
        .p     (p[CHUNK:LO+1]),
        .g     (g[CHUNK:LO+1]),
        .grp_p (hi_p),
        .grp_g (hi_g)
      );

      assign grp_p[LO:1] = lo_p;
      assign grp_g[LO:1] = lo_g;

      // Fold the lower half's full-span group into each upper-half prefix.
      always_comb begin
        for (int i = 1; i <= HI; i++) begin
          {grp_g[LO+i], grp_p[LO+i]} = gp_merge(hi_g[i], hi_p[i], lo_g[LO], lo_p[LO]);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/seq_prefix_addsub.sv
// Multi-cycle WIDTH-bit add/subtract, one CHUNK-bit slice per cycle through a
// shared prefix network, with a registered carry between slices.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for operands; result registers hold the last result
//   ST_RUN  | computing slice idx (LSB first), carry chained in register
//   ST_DONE | result valid, held stable until out_ready
module seq_prefix_addsub
  import seq_prefix_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if (!width_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("seq_prefix_addsub: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_t          state;
  logic [IDXW-1:0] idx;
  logic            carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic            cout_q;
  logic            ovf_q;

  int              lsb;
  logic [CHUNK:1]  p;
  logic [CHUNK:1]  g;
  logic [CHUNK:1]  grp_p;
  logic [CHUNK:1]  grp_g;
  logic [CHUNK:1]  c;
  logic [CHUNK:1]  sum_k;
  logic            carry_next;
  logic            c_msb;

  assign in_ready  = (state == ST_IDLE) && !rst;
  assign out_valid = (state == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Select the current slice of the latched operands.
  always_comb begin
    lsb = int'(idx) * CHUNK;
    p   = a_q[lsb +: CHUNK] ^ b_q[lsb +: CHUNK];
    g   = a_q[lsb +: CHUNK] & b_q[lsb +: CHUNK];
  end

  gp_prefix_chunk #(.CHUNK(CHUNK)) u_prefix (
    .p     (p),
    .g     (g),
    .grp_p (grp_p),
    .grp_g (grp_g)
  );

  // Turn prefix groups plus the incoming slice carry into per-bit carries.
  always_comb begin
    c    = '0;
    c[1] = carry;
    for (int i = 2; i <= CHUNK; i++) begin
      c[i] = grp_g[i-1] | (grp_p[i-1] & carry);
    end
    sum_k      = p ^ c;
    carry_next = grp_g[CHUNK] | (grp_p[CHUNK] & carry);
    c_msb      = c[CHUNK];
  end

  // Sequencer: latch operands, walk the slices, then hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b ^ {WIDTH{sub}};
            carry <= sub;
            idx   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[lsb +: CHUNK] <= sum_k;
          carry               <= carry_next;
          if (idx == LAST_IDX) begin
            cout_q <= carry_next;
            ovf_q  <= c_msb ^ carry_next;
            state  <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_prefix_addsub.sv
// Self-checking bench: directed corner cases on a CHUNK=8 instance, then
// randomized back-to-back traffic on CHUNK=4, 32 and 8 instances.
module tb_seq_prefix_addsub;

  localparam int W = 32;

  logic        clk;
  logic        rst;
  logic        in_valid_v [3];
  logic        in_ready_v [3];
  logic [W-1:0] a_v       [3];
  logic [W-1:0] b_v       [3];
  logic        sub_v      [3];
  logic        out_valid_v[3];
  logic        out_ready_v[3];
  logic [W-1:0] sum_v     [3];
  logic        cout_v     [3];
  logic        ovf_v      [3];

  int n_vec;
  int n_err;
  int cur_j;
  int cycle;
  int last_acc [3];
  bit have_last[3];

  seq_prefix_addsub #(.WIDTH(W), .CHUNK(8)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0]), .b(b_v[0]), .sub(sub_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));

  seq_prefix_addsub #(.WIDTH(W), .CHUNK(32)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1]), .b(b_v[1]), .sub(sub_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));

  seq_prefix_addsub #(.WIDTH(W), .CHUNK(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2]), .b(b_v[2]), .sub(sub_v[2]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic int nch_of(input int j);
    case (j)
      0:       return 8 / 8 * 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", tag, cur_j, got, exp, $time);
    end
  endtask

  // Reference: plain integer add of a and the two's-complement of b.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                       output logic [W-1:0] es, output logic ec, output logic eo);
    logic [W:0] full;
    if (sv) full = {1'b0, av} + {1'b0, ~bv} + 33'd1;
    else    full = {1'b0, av} + {1'b0, bv};
    es = full[W-1:0];
    ec = full[W];
    if (sv) eo = (av[W-1] != bv[W-1]) && (es[W-1] != av[W-1]);
    else    eo = (av[W-1] == bv[W-1]) && (es[W-1] != av[W-1]);
  endtask

  // One operation from IDLE; hold > 0 keeps out_ready low that many cycles.
  task automatic run_op(input int j, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv, input int hold,
                        output logic [W-1:0] gs, output logic gc, output logic go);
    int cyc;
    logic [W-1:0] es;
    logic ec, eo;
    cur_j = j;
    model(av, bv, sv, es, ec, eo);
    out_ready_v[j] = (hold == 0);
    check("in_ready_idle", in_ready_v[j], 1);
    check("out_valid_idle", out_valid_v[j], 0);
    a_v[j] = av; b_v[j] = bv; sub_v[j] = sv; in_valid_v[j] = 1'b1;
    if (have_last[j]) check("issue_interval", cycle - last_acc[j], nch_of(j) + 2);
    last_acc[j] = cycle; have_last[j] = 1'b1;
    @(negedge clk);
    in_valid_v[j] = 1'b0;
    a_v[j] = $urandom; b_v[j] = $urandom; sub_v[j] = ~sv;
    check("in_ready_busy", in_ready_v[j], 0);
    cyc = 1;
    while (!out_valid_v[j] && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, nch_of(j) + 1);
    gs = sum_v[j]; gc = cout_v[j]; go = ovf_v[j];
    check("sum", sum_v[j], es);
    check("cout", cout_v[j], ec);
    check("ovf", ovf_v[j], eo);
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        in_valid_v[j] = k[0];
        a_v[j] = $urandom;
        @(negedge clk);
        check("bp_valid", out_valid_v[j], 1);
        check("bp_in_ready", in_ready_v[j], 0);
        check("bp_sum", sum_v[j], es);
        check("bp_flags", {cout_v[j], ovf_v[j]}, {ec, eo});
      end
      in_valid_v[j] = 1'b0;
      out_ready_v[j] = 1'b1;
    end
    @(negedge clk);
    if (hold > 0) begin
      check("bp_release_ready", in_ready_v[j], 1);
      check("bp_release_valid", out_valid_v[j], 0);
    end
  endtask

  logic [W-1:0] dir_a [6];
  logic [W-1:0] dir_b [6];
  logic         dir_s [6];
  logic [W-1:0] dir_sum [6];
  logic [1:0]   dir_fl [6];

  initial begin
    logic [W-1:0] gs, ra, rb;
    logic gc, go;
    n_vec = 0; n_err = 0; cur_j = 0; cycle = 0;
    for (int j = 0; j < 3; j++) begin
      in_valid_v[j] = 0; a_v[j] = 0; b_v[j] = 0; sub_v[j] = 0; out_ready_v[j] = 1;
      have_last[j] = 0; last_acc[j] = 0;
    end
    // {cout, ovf} in dir_fl
    dir_a[0] = 32'hFFFF_FFFF; dir_b[0] = 32'h0000_0001; dir_s[0] = 0; dir_sum[0] = 32'h0000_0000; dir_fl[0] = 2'b10;
    dir_a[1] = 32'h7FFF_FFFF; dir_b[1] = 32'h0000_0001; dir_s[1] = 0; dir_sum[1] = 32'h8000_0000; dir_fl[1] = 2'b01;
    dir_a[2] = 32'h00FF_FFFF; dir_b[2] = 32'h0000_0001; dir_s[2] = 0; dir_sum[2] = 32'h0100_0000; dir_fl[2] = 2'b00;
    dir_a[3] = 32'h0000_0005; dir_b[3] = 32'h0000_0007; dir_s[3] = 1; dir_sum[3] = 32'hFFFF_FFFE; dir_fl[3] = 2'b00;
    dir_a[4] = 32'h8000_0000; dir_b[4] = 32'h0000_0001; dir_s[4] = 1; dir_sum[4] = 32'h7FFF_FFFF; dir_fl[4] = 2'b11;
    dir_a[5] = 32'h1234_5678; dir_b[5] = 32'h1234_5678; dir_s[5] = 1; dir_sum[5] = 32'h0000_0000; dir_fl[5] = 2'b10;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      cur_j = j;
      check("rst_in_ready", in_ready_v[j], 0);
      check("rst_out_valid", out_valid_v[j], 0);
      check("rst_sum", sum_v[j], 0);
      check("rst_flags", {cout_v[j], ovf_v[j]}, 2'b00);
    end
    rst = 1'b0;
    #1;

    // Directed corners, back to back on the CHUNK=8 instance.
    for (int t = 0; t < 6; t++) begin
      run_op(0, dir_a[t], dir_b[t], dir_s[t], 0, gs, gc, go);
      check("dir_sum", gs, dir_sum[t]);
      check("dir_flags", {gc, go}, dir_fl[t]);
    end

    // Backpressure: result held for 10 cycles with in_valid pulses.
    have_last[0] = 0;
    run_op(0, 32'hDEAD_BEEF, 32'h2152_4111, 0, 10, gs, gc, go);

    // Reset two edges after accept abandons the operation.
    cur_j = 0;
    check("pre_rst_ready", in_ready_v[0], 1);
    a_v[0] = 32'h1234_5678; b_v[0] = 32'h1111_1111; sub_v[0] = 0; in_valid_v[0] = 1;
    @(negedge clk);
    in_valid_v[0] = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", out_valid_v[0], 0);
    check("mid_rst_sum", sum_v[0], 0);
    check("mid_rst_ready", in_ready_v[0], 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready_v[0], 1);
    @(negedge clk);
    check("post_rst_idle_valid", out_valid_v[0], 0);
    have_last[0] = 0;
    run_op(0, 32'h0F0F_F0F0, 32'h00FF_FF01, 0, 0, gs, gc, go);

    // Randomized back-to-back traffic on every slice configuration.
    for (int j = 0; j < 3; j++) begin
      have_last[j] = 0;
      for (int n = 0; n < 40; n++) begin
        case ($urandom_range(0, 4))
          0: ra = 32'hFFFF_FFFF;
          1: ra = 32'h8000_0000;
          2: ra = 32'h7FFF_FFFF;
          default: ra = $urandom;
        endcase
        case ($urandom_range(0, 4))
          0: rb = 32'h0000_0001;
          1: rb = 32'h8000_0000;
          2: rb = ra;
          default: rb = $urandom;
        endcase
        run_op(j, ra, rb, 1'($urandom_range(0, 1)), 0, gs, gc, go);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
